ysyx_24100006_idu_sb: RTL and testbench
=======================================

// Module: ysyx_24100006_idu_sb
// PURPOSE
//   Registered decode stage with scoreboard. Sits between the IF_ID and ID_EXE registers.
//   Reads the GPR file and blocks any instruction whose source register has a write in flight.
//   Delivers {pc, inst, rs1/rs2 data, rd, rd_wen} through a one-entry valid/ready output
//   register, so an external hazard unit is no longer needed for GPR RAW hazards.
//   CSR access, immediates and ALU control are out of scope; they stay with the existing
//   combinational decode.
// PARAMETERS
//   NR_REG   16  GPR count; must be 16 or 32. Index width RW = $clog2(NR_REG); x0 reads 0, never pending.
//   XLEN     32  datapath width.
//   CNT_W    2   per-register pending-write counter width; max outstanding = 2**CNT_W-1.
// PORTS
//   clk           in   1      clock; all state changes on rising edge.
//   reset         in   1      asynchronous, active-low reset.
//   in_valid      in   1      IF_ID holds an instruction.
//   in_ready      out  1      the instruction is accepted this cycle.
//   in_pc         in   XLEN   pc of the instruction.
//   in_inst       in   32     instruction word.
//   flush         in   1      redirect: kills the output-register entry and any accept this cycle.
//   out_valid     out  1      the output register holds an entry.
//   out_ready     in   1      ID_EXE takes the entry.
//   out_pc        out  XLEN   registered pc.
//   out_inst      out  32     registered instruction.
//   out_rs1_data  out  XLEN   registered rs1 value.
//   out_rs2_data  out  XLEN   registered rs2 value.
//   out_rd        out  RW     registered rd index.
//   out_rd_wen    out  1      entry writes rd (rd!=0).
//   wb_wen        in   1      writeback commits.
//   wb_addr       in   RW     writeback register index.
//   wb_data       in   XLEN   writeback data.
//   sb_busy       out  1      OR of all pending counters; debug and fence_i drain.
// BEHAVIOUR
//   Reset: out_valid=0; all out_* data=0; every counter=0; GPR contents are not reset.
//     in_ready is 0 while reset is asserted.
//   Source use (opcode):
//     rs1 only: JALR, LOAD, OP-IMM, SYSTEM (funct3!=0).
//     rs1 and rs2: BRANCH, STORE, OP.
//     none: LUI, AUIPC, JAL, others.
//   rd write: LUI, AUIPC, JAL, JALR, LOAD, OP-IMM, OP, SYSTEM (funct3!=0), and only when rd!=0.
//   Register indices: inst[15+:RW], inst[20+:RW], inst[7+:RW].
//   A source register is busy if cnt[rs]!=0, or if out_valid && out_rd_wen && out_rd==rs.
//   A write is blocked if cnt[rd] is saturated (rd counts entries already in EX..WB).
//   in_ready = !flush && !hazard && !sat && (!out_valid || out_ready).
//   Accept (in_valid && in_ready): the output register loads next edge. Latency 1 cycle.
//   Output entry is held stable while out_valid && !out_ready.
//   Issue = out_valid && out_ready && !flush: cnt[out_rd] += 1 if out_rd_wen.
//   wb_wen && wb_addr!=0: cnt[wb_addr] -= 1 and the GPR is written.
//   Issue and writeback to the same register in one cycle: counter is unchanged.
//   Decrement at 0 is ignored (never underflows); an assertion flags it in simulation.
//   flush: out_valid<=0 next edge; counters untouched; in-flight writebacks still drain.
//   Reset mid-operation: all entries and counters are dropped immediately (asynchronous).
// CONFIGURATION
//   YSYX_IDU_WB_BYPASS_EN defined:
//     A same-cycle writeback to rs supplies wb_data into the captured source value.
//     That source is not treated as busy when cnt[rs]==1 and no match exists in the output register.
//   Not defined:
//     The source stalls until one cycle after the writeback; the GPR read then returns the new value.
// STRUCTURE
//   Shared package ysyx_24100006_pkg: opcode localparams (OP_LUI..OP_SYSTEM), RW function, decode bundle struct.
//   Sub-module ysyx_24100006_gpr_nr: NR_REG x XLEN register file, 2 async read ports, 1 write port, x0=0.
//   Scoreboard counters, hazard logic and the output register stay inline.
// TESTING
//   1. Reset asserted with traffic pending -> out_valid=0, sb_busy=0, in_ready=0 until reset deasserts.
//   2. addi x5,x0,7 issued; add x6,x5,x5 follows -> the add stalls (in_ready=0) until wb x5=7.
//      With bypass: the add accepts in the writeback cycle with rs1=rs2=7.
//      Without bypass: the add accepts 1 cycle later.
//   3. out_ready=0 for 5 cycles with the entry valid -> out_* stay stable and in_ready=0;
//      next cycle out_ready=1 -> the entry issues and cnt[rd]=1.
//   4. Three writes to x3 issued with CNT_W=2, then a 4th write to x3 -> the 4th stalls
//      until one wb x3; a reader of x3 waits for all three writebacks.
//   5. flush with an entry holding rd=x4 -> out_valid=0, cnt[4] unchanged (0);
//      an instruction reading x4 next cycle accepts without stall.
//   6. Issue to x8 and wb x8 in the same cycle with cnt[8]=1 -> cnt[8] stays 1, sb_busy=1.
//      Writes to x0 never change any counter.

Source files
------------

// File: rtl/ysyx_24100006_pkg.sv
// Shared decode definitions for the ysyx_24100006 core: opcodes, index-width helper,
// and the operand-use bundle produced by the scoreboard decode.
package ysyx_24100006_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OP_IMM = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef struct packed {
        logic use_rs1;
        logic use_rs2;
        logic wr_rd;
    } dec_use_t;

    function automatic int rw_of(input int nr_reg);
        return $clog2(nr_reg);
    endfunction

    // SYSTEM with funct3==0 (ecall/ebreak/mret) touches no GPR
    function automatic dec_use_t decode_use(input logic [6:0] opcode, input logic [2:0] funct3);
        dec_use_t d;
        case (opcode)
            OP_LUI, OP_AUIPC, OP_JAL:    d = '{use_rs1: 1'b0, use_rs2: 1'b0, wr_rd: 1'b1};
            OP_JALR, OP_LOAD, OP_OP_IMM: d = '{use_rs1: 1'b1, use_rs2: 1'b0, wr_rd: 1'b1};
            OP_BRANCH, OP_STORE:         d = '{use_rs1: 1'b1, use_rs2: 1'b1, wr_rd: 1'b0};
            OP_OP:                       d = '{use_rs1: 1'b1, use_rs2: 1'b1, wr_rd: 1'b1};
            OP_SYSTEM: begin
                if (funct3 != 3'b000) d = '{use_rs1: 1'b1, use_rs2: 1'b0, wr_rd: 1'b1};
                else                  d = '{use_rs1: 1'b0, use_rs2: 1'b0, wr_rd: 1'b0};
            end
            default:                     d = '{use_rs1: 1'b0, use_rs2: 1'b0, wr_rd: 1'b0};
        endcase
        return d;
    endfunction

endpackage

// File: rtl/ysyx_24100006_idu_sb_if.sv
// Handshake and writeback bundle of the scoreboarded decode stage.
interface ysyx_24100006_idu_sb_if #(
    parameter int XLEN = 32,
    parameter int RW   = 4
);
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_pc;
    logic [31:0]     in_inst;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [31:0]     out_inst;
    logic [XLEN-1:0] out_rs1_data;
    logic [XLEN-1:0] out_rs2_data;
    logic [RW-1:0]   out_rd;
    logic            out_rd_wen;
    logic            wb_wen;
    logic [RW-1:0]   wb_addr;
    logic [XLEN-1:0] wb_data;
    logic            sb_busy;

    modport master (
        output in_valid, in_pc, in_inst, flush, out_ready, wb_wen, wb_addr, wb_data,
        input  in_ready, out_valid, out_pc, out_inst, out_rs1_data, out_rs2_data,
               out_rd, out_rd_wen, sb_busy
    );

    modport slave (
        input  in_valid, in_pc, in_inst, flush, out_ready, wb_wen, wb_addr, wb_data,
        output in_ready, out_valid, out_pc, out_inst, out_rs1_data, out_rs2_data,
               out_rd, out_rd_wen, sb_busy
    );
endinterface

// File: rtl/ysyx_24100006_gpr_nr.sv
// NR_REG x XLEN general-purpose register file: two async read ports, one write port, x0 hardwired to 0.
module ysyx_24100006_gpr_nr #(
    parameter int NR_REG = 16,
    parameter int XLEN   = 32,
    parameter int RW     = 4
) (
    input  logic            clk,
    input  logic [RW-1:0]   raddr1,
    input  logic [RW-1:0]   raddr2,
    output logic [XLEN-1:0] rdata1,
    output logic [XLEN-1:0] rdata2,
    input  logic            wen,
    input  logic [RW-1:0]   waddr,
    input  logic [XLEN-1:0] wdata
);
    localparam logic [RW-1:0]   IDX_ZERO  = {RW{1'b0}};
    localparam logic [XLEN-1:0] DATA_ZERO = {XLEN{1'b0}};

    logic [XLEN-1:0] regs_r [NR_REG];

    // Register write; contents are deliberately left unreset
    always_ff @(posedge clk) begin
        if (wen && (waddr != IDX_ZERO)) begin
            regs_r[waddr] <= wdata;
        end
    end

    assign rdata1 = (raddr1 == IDX_ZERO) ? DATA_ZERO : regs_r[raddr1];
    assign rdata2 = (raddr2 == IDX_ZERO) ? DATA_ZERO : regs_r[raddr2];
endmodule

// File: rtl/ysyx_24100006_idu_sb_chk.sv
// Simulation checker for the decode scoreboard.
module ysyx_24100006_idu_sb_chk (
    input logic clk,
    input logic reset,
    input logic underflow
);
    // A writeback must always retire a write that the scoreboard is tracking
    assert property (@(posedge clk) disable iff (!reset) !underflow)
        else $error("scoreboard counter decremented at zero");
endmodule

// File: rtl/ysyx_24100006_idu_sb.sv
// Registered decode stage with a per-GPR pending-write scoreboard and a one-entry output register.
// Optional YSYX_IDU_WB_BYPASS_EN forwards a same-cycle writeback into the captured source operands.
module ysyx_24100006_idu_sb
    import ysyx_24100006_pkg::*;
#(
    parameter int NR_REG = 16,
    parameter int XLEN   = 32,
    parameter int CNT_W  = 2
) (
    input logic                  clk,
    input logic                  reset,
    ysyx_24100006_idu_sb_if.slave bus
);
    localparam int RW = rw_of(NR_REG);

    localparam logic [RW-1:0]     IDX_ZERO  = {RW{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  CNT_NEAR  = CNT_MAX - CNT_ONE;
    localparam logic [NR_REG-1:0] VEC_ZERO  = {NR_REG{1'b0}};
    localparam logic [NR_REG-1:0] VEC_ONE   = {{(NR_REG-1){1'b0}}, 1'b1};
    localparam logic [XLEN-1:0]   DATA_ZERO = {XLEN{1'b0}};

    logic [CNT_W-1:0]  cnt_r      [NR_REG];
    logic [CNT_W-1:0]  cnt_nxt_s  [NR_REG];
    logic              sb_busy_r;
    logic              busy_nxt_s;

    logic              out_valid_r;
    logic [XLEN-1:0]   out_pc_r;
    logic [31:0]       out_inst_r;
    logic [XLEN-1:0]   out_rs1_r;
    logic [XLEN-1:0]   out_rs2_r;
    logic [RW-1:0]     out_rd_r;
    logic              out_rd_wen_r;

    dec_use_t          dec_s;
    logic [RW-1:0]     rs1_s, rs2_s, rd_s;
    logic              rd_wen_s;
    logic [XLEN-1:0]   gpr_rdata1_s, gpr_rdata2_s;
    logic [XLEN-1:0]   rs1_val_s, rs2_val_s;
    logic [CNT_W-1:0]  cnt_rs1_s, cnt_rs2_s, cnt_rd_s;
    logic              out_hit1_s, out_hit2_s, out_hitd_s;
    logic              rs1_busy_s, rs2_busy_s, sat_s;
    logic              in_ready_s, accept_s, issue_s, wb_hit_s, underflow_s;
    logic [NR_REG-1:0] inc_vec_s, dec_vec_s;

    assign dec_s    = decode_use(bus.in_inst[6:0], bus.in_inst[14:12]);
    assign rs1_s    = bus.in_inst[15 +: RW];
    assign rs2_s    = bus.in_inst[20 +: RW];
    assign rd_s     = bus.in_inst[7 +: RW];
    assign rd_wen_s = dec_s.wr_rd && (rd_s != IDX_ZERO);

    ysyx_24100006_gpr_nr #(.NR_REG(NR_REG), .XLEN(XLEN), .RW(RW)) u_gpr (
        .clk    (clk),
        .raddr1 (rs1_s),
        .raddr2 (rs2_s),
        .rdata1 (gpr_rdata1_s),
        .rdata2 (gpr_rdata2_s),
        .wen    (wb_hit_s),
        .waddr  (bus.wb_addr),
        .wdata  (bus.wb_data)
    );

    assign cnt_rs1_s  = cnt_r[rs1_s];
    assign cnt_rs2_s  = cnt_r[rs2_s];
    assign cnt_rd_s   = cnt_r[rd_s];
    assign out_hit1_s = out_valid_r && out_rd_wen_r && (out_rd_r == rs1_s);
    assign out_hit2_s = out_valid_r && out_rd_wen_r && (out_rd_r == rs2_s);
    assign out_hitd_s = out_valid_r && out_rd_wen_r && (out_rd_r == rd_s);
    assign wb_hit_s   = bus.wb_wen && (bus.wb_addr != IDX_ZERO);

`ifdef YSYX_IDU_WB_BYPASS_EN
    logic wb_byp1_s, wb_byp2_s;
    assign wb_byp1_s  = wb_hit_s && (bus.wb_addr == rs1_s);
    assign wb_byp2_s  = wb_hit_s && (bus.wb_addr == rs2_s);
    // The last outstanding write retiring this cycle is satisfied by the forwarded data
    assign rs1_busy_s = dec_s.use_rs1 && (rs1_s != IDX_ZERO) &&
                        (out_hit1_s || ((cnt_rs1_s != CNT_ZERO) && !((cnt_rs1_s == CNT_ONE) && wb_byp1_s)));
    assign rs2_busy_s = dec_s.use_rs2 && (rs2_s != IDX_ZERO) &&
                        (out_hit2_s || ((cnt_rs2_s != CNT_ZERO) && !((cnt_rs2_s == CNT_ONE) && wb_byp2_s)));
    assign rs1_val_s  = wb_byp1_s ? bus.wb_data : gpr_rdata1_s;
    assign rs2_val_s  = wb_byp2_s ? bus.wb_data : gpr_rdata2_s;
`else
    assign rs1_busy_s = dec_s.use_rs1 && (rs1_s != IDX_ZERO) && (out_hit1_s || (cnt_rs1_s != CNT_ZERO));
    assign rs2_busy_s = dec_s.use_rs2 && (rs2_s != IDX_ZERO) && (out_hit2_s || (cnt_rs2_s != CNT_ZERO));
    assign rs1_val_s  = gpr_rdata1_s;
    assign rs2_val_s  = gpr_rdata2_s;
`endif

    // A write held in the output register will issue ahead of us, so it counts against the limit
    assign sat_s      = rd_wen_s && ((cnt_rd_s == CNT_MAX) || ((cnt_rd_s == CNT_NEAR) && out_hitd_s));
    assign in_ready_s = reset && !bus.flush && !rs1_busy_s && !rs2_busy_s && !sat_s &&
                        (!out_valid_r || bus.out_ready);
    assign accept_s   = bus.in_valid && in_ready_s;
    assign issue_s    = out_valid_r && bus.out_ready && !bus.flush;

    assign inc_vec_s   = (issue_s && out_rd_wen_r) ? (VEC_ONE << out_rd_r) : VEC_ZERO;
    assign dec_vec_s   = wb_hit_s ? (VEC_ONE << bus.wb_addr) : VEC_ZERO;
    assign underflow_s = wb_hit_s && (cnt_r[bus.wb_addr] == CNT_ZERO) && !inc_vec_s[bus.wb_addr];

    // Next pending-write count per register and the resulting busy flag
    always_comb begin
        cnt_nxt_s[0] = CNT_ZERO;
        busy_nxt_s   = 1'b0;
        for (int i = 1; i < NR_REG; i++) begin
            if (inc_vec_s[i] && !dec_vec_s[i]) begin
                cnt_nxt_s[i] = cnt_r[i] + CNT_ONE;
            end else if (dec_vec_s[i] && !inc_vec_s[i] && (cnt_r[i] != CNT_ZERO)) begin
                cnt_nxt_s[i] = cnt_r[i] - CNT_ONE;
            end else begin
                cnt_nxt_s[i] = cnt_r[i];
            end
            busy_nxt_s = busy_nxt_s | (cnt_nxt_s[i] != CNT_ZERO);
        end
    end

    // Scoreboard counters
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NR_REG; i++) begin
                cnt_r[i] <= CNT_ZERO;
            end
            sb_busy_r <= 1'b0;
        end else begin
            for (int i = 0; i < NR_REG; i++) begin
                cnt_r[i] <= cnt_nxt_s[i];
            end
            sb_busy_r <= busy_nxt_s;
        end
    end

    // One-entry output register toward ID_EXE
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid_r  <= 1'b0;
            out_pc_r     <= DATA_ZERO;
            out_inst_r   <= 32'h0000_0000;
            out_rs1_r    <= DATA_ZERO;
            out_rs2_r    <= DATA_ZERO;
            out_rd_r     <= IDX_ZERO;
            out_rd_wen_r <= 1'b0;
        end else if (bus.flush) begin
            out_valid_r  <= 1'b0;
        end else if (accept_s) begin
            out_valid_r  <= 1'b1;
            out_pc_r     <= bus.in_pc;
            out_inst_r   <= bus.in_inst;
            out_rs1_r    <= rs1_val_s;
            out_rs2_r    <= rs2_val_s;
            out_rd_r     <= rd_s;
            out_rd_wen_r <= rd_wen_s;
        end else if (bus.out_ready) begin
            out_valid_r  <= 1'b0;
        end
    end

    assign bus.in_ready     = in_ready_s;
    assign bus.out_valid    = out_valid_r;
    assign bus.out_pc       = out_pc_r;
    assign bus.out_inst     = out_inst_r;
    assign bus.out_rs1_data = out_rs1_r;
    assign bus.out_rs2_data = out_rs2_r;
    assign bus.out_rd       = out_rd_r;
    assign bus.out_rd_wen   = out_rd_wen_r;
    assign bus.sb_busy      = sb_busy_r;

    ysyx_24100006_idu_sb_chk u_chk (
        .clk       (clk),
        .reset     (reset),
        .underflow (underflow_s)
    );
endmodule

// File: tb/tb_ysyx_24100006_idu_sb.sv
// Directed bench for ysyx_24100006_idu_sb (NR_REG=16, CNT_W=2); honours YSYX_IDU_WB_BYPASS_EN.
module tb_ysyx_24100006_idu_sb;
    localparam logic [31:0] ADDI_X5   = 32'h0070_0293; // addi x5,x0,7
    localparam logic [31:0] ADD_X6    = 32'h0052_8333; // add  x6,x5,x5
    localparam logic [31:0] ADD_X7_65 = 32'h0053_03B3; // add  x7,x6,x5
    localparam logic [31:0] NOP       = 32'h0000_0013;
    localparam logic [31:0] ADDI_X3   = 32'h0010_0193; // addi x3,x0,1
    localparam logic [31:0] ADD_X7_33 = 32'h0031_83B3; // add  x7,x3,x3
    localparam logic [31:0] ADDI_X4   = 32'h0090_0213; // addi x4,x0,9
    localparam logic [31:0] ADD_X9    = 32'h0042_04B3; // add  x9,x4,x4
    localparam logic [31:0] ADDI_X8   = 32'h0010_0413; // addi x8,x0,1
    localparam logic [31:0] ADD_X10   = 32'h0004_0533; // add  x10,x8,x0
`ifdef YSYX_IDU_WB_BYPASS_EN
    localparam logic BP = 1'b1;
`else
    localparam logic BP = 1'b0;
`endif

    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;

    ysyx_24100006_idu_sb_if #(.XLEN(32), .RW(4)) bus ();

    ysyx_24100006_idu_sb #(.NR_REG(16), .XLEN(32), .CNT_W(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] inst);
        bus.in_valid = v;
        bus.in_pc    = pc;
        bus.in_inst  = inst;
    endtask

    task automatic wb(input logic en, input logic [3:0] addr, input logic [31:0] data);
        bus.wb_wen  = en;
        bus.wb_addr = addr;
        bus.wb_data = data;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b1;
        bus.flush = 1'b0;
        bus.out_ready = 1'b1;
        wb(1'b0, 4'd0, 32'h0);
        drive(1'b1, 32'h100, ADDI_X5);
        #2 reset = 1'b0;

        // reset with traffic presented
        @(negedge clk); #1;
        chk("rst_in_ready", bus.in_ready, 1'b0);
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_sb_busy", bus.sb_busy, 1'b0);
        chk("rst_out_pc", bus.out_pc, 32'h0);
        @(negedge clk);
        drive(1'b0, 32'h0, NOP);
        reset = 1'b1;

        // RAW on x5
        @(negedge clk); drive(1'b1, 32'h100, ADDI_X5); #1;
        chk("t2_addi_ready", bus.in_ready, 1'b1);
        @(negedge clk); drive(1'b1, 32'h104, ADD_X6); #1;
        chk("t2_out_valid", bus.out_valid, 1'b1);
        chk("t2_out_pc", bus.out_pc, 32'h100);
        chk("t2_out_rd", bus.out_rd, 4'd5);
        chk("t2_out_rd_wen", bus.out_rd_wen, 1'b1);
        chk("t2_out_rs1_x0", bus.out_rs1_data, 32'h0);
        chk("t2_stall_outreg", bus.in_ready, 1'b0);
        @(negedge clk); #1;
        chk("t2_issued", bus.out_valid, 1'b0);
        chk("t2_busy", bus.sb_busy, 1'b1);
        chk("t2_stall_cnt", bus.in_ready, 1'b0);
        @(negedge clk); wb(1'b1, 4'd5, 32'd7); #1;
        chk("t2_wb_cycle_ready", bus.in_ready, BP);
        @(negedge clk); wb(1'b0, 4'd0, 32'h0);
`ifndef YSYX_IDU_WB_BYPASS_EN
        #1;
        chk("t2_ready_after_wb", bus.in_ready, 1'b1);
        chk("t2_not_yet_loaded", bus.out_valid, 1'b0);
        @(negedge clk);
`endif
        drive(1'b0, 32'h0, NOP); #1;
        chk("t2_add_valid", bus.out_valid, 1'b1);
        chk("t2_add_pc", bus.out_pc, 32'h104);
        chk("t2_add_rs1", bus.out_rs1_data, 32'd7);
        chk("t2_add_rs2", bus.out_rs2_data, 32'd7);
        chk("t2_add_rd", bus.out_rd, 4'd6);
        @(negedge clk); wb(1'b1, 4'd6, 32'd14); #1;
        chk("t2_x6_busy", bus.sb_busy, 1'b1);
        @(negedge clk); wb(1'b0, 4'd0, 32'h0); #1;
        chk("t2_idle", bus.sb_busy, 1'b0);

        // backpressure holds the entry
        bus.out_ready = 1'b0;
        drive(1'b1, 32'h200, ADD_X7_65); #1;
        chk("t3_accept", bus.in_ready, 1'b1);
        @(negedge clk); drive(1'b1, 32'h204, NOP);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("t3_hold_valid", bus.out_valid, 1'b1);
            chk("t3_hold_pc", bus.out_pc, 32'h200);
            chk("t3_hold_rs1", bus.out_rs1_data, 32'd14);
            chk("t3_hold_rs2", bus.out_rs2_data, 32'd7);
            chk("t3_hold_ready", bus.in_ready, 1'b0);
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        drive(1'b0, 32'h0, NOP); #1;
        chk("t3_still_pc", bus.out_pc, 32'h200);
        @(negedge clk); #1;
        chk("t3_issued", bus.out_valid, 1'b0);
        chk("t3_cnt7", bus.sb_busy, 1'b1);
        wb(1'b1, 4'd7, 32'h15);
        @(negedge clk); wb(1'b0, 4'd0, 32'h0); #1;
        chk("t3_idle", bus.sb_busy, 1'b0);

        // saturation of x3
        drive(1'b1, 32'h300, ADDI_X3); #1;
        chk("t4_w1_ready", bus.in_ready, 1'b1);
        @(negedge clk); drive(1'b1, 32'h304, ADDI_X3); #1;
        chk("t4_w2_ready", bus.in_ready, 1'b1);
        @(negedge clk); drive(1'b1, 32'h308, ADDI_X3); #1;
        chk("t4_w3_ready", bus.in_ready, 1'b1);
        @(negedge clk); drive(1'b0, 32'h0, NOP);
        @(negedge clk); drive(1'b1, 32'h30c, ADDI_X3); #1;
        chk("t4_sat_stall", bus.in_ready, 1'b0);
        chk("t4_sat_busy", bus.sb_busy, 1'b1);
        chk("t4_sat_empty", bus.out_valid, 1'b0);
        @(negedge clk); #1;
        chk("t4_sat_stall2", bus.in_ready, 1'b0);
        @(negedge clk); wb(1'b1, 4'd3, 32'd1); #1;
        chk("t4_sat_wb_cycle", bus.in_ready, 1'b0);
        @(negedge clk); wb(1'b0, 4'd0, 32'h0); #1;
        chk("t4_w4_ready", bus.in_ready, 1'b1);
        @(negedge clk); drive(1'b1, 32'h310, ADD_X7_33); #1;
        chk("t4_w4_pc", bus.out_pc, 32'h30c);
        chk("t4_reader_stall", bus.in_ready, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); wb(1'b1, 4'd3, 32'(i + 1)); #1;
            chk("t4_reader_wait", bus.in_ready, (BP && (i == 2)) ? 1'b1 : 1'b0);
        end
        @(negedge clk); wb(1'b0, 4'd0, 32'h0);
`ifndef YSYX_IDU_WB_BYPASS_EN
        #1;
        chk("t4_reader_ready", bus.in_ready, 1'b1);
        @(negedge clk);
`endif
        drive(1'b0, 32'h0, NOP); #1;
        chk("t4_reader_valid", bus.out_valid, 1'b1);
        chk("t4_reader_pc", bus.out_pc, 32'h310);
        chk("t4_reader_rs1", bus.out_rs1_data, 32'd3);
        chk("t4_reader_rs2", bus.out_rs2_data, 32'd3);
        @(negedge clk); wb(1'b1, 4'd7, 32'h33);
        @(negedge clk); wb(1'b0, 4'd0, 32'h0); #1;
        chk("t4_idle", bus.sb_busy, 1'b0);

        // flush of an entry writing x4
        bus.out_ready = 1'b0;
        drive(1'b1, 32'h400, ADDI_X4); #1;
        chk("t5_accept", bus.in_ready, 1'b1);
        @(negedge clk); drive(1'b0, 32'h0, NOP); bus.flush = 1'b1; #1;
        chk("t5_flush_ready", bus.in_ready, 1'b0);
        chk("t5_entry_rd", bus.out_rd, 4'd4);
        @(negedge clk); bus.flush = 1'b0; bus.out_ready = 1'b1;
        drive(1'b1, 32'h404, ADD_X9); #1;
        chk("t5_flushed", bus.out_valid, 1'b0);
        chk("t5_cnt4_zero", bus.sb_busy, 1'b0);
        chk("t5_reader_ready", bus.in_ready, 1'b1);
        @(negedge clk); drive(1'b0, 32'h0, NOP); bus.flush = 1'b1; #1;
        chk("t5_reader_pc", bus.out_pc, 32'h404);
        chk("t5_reader_rd", bus.out_rd, 4'd9);
        @(negedge clk); bus.flush = 1'b0; #1;
        chk("t5_kill", bus.out_valid, 1'b0);
        chk("t5_idle", bus.sb_busy, 1'b0);

        // issue and writeback to x8 in one cycle
        @(negedge clk); drive(1'b1, 32'h500, ADDI_X8);
        @(negedge clk); drive(1'b0, 32'h0, NOP);
        @(negedge clk); drive(1'b1, 32'h504, ADDI_X8); #1;
        chk("t6_w2_ready", bus.in_ready, 1'b1);
        chk("t6_cnt8_one", bus.sb_busy, 1'b1);
        @(negedge clk); drive(1'b0, 32'h0, NOP); wb(1'b1, 4'd8, 32'h55); #1;
        chk("t6_w2_valid", bus.out_valid, 1'b1);
        @(negedge clk); wb(1'b1, 4'd0, 32'hff); #1;
        chk("t6_same_cycle", bus.sb_busy, 1'b1);
        chk("t6_issued", bus.out_valid, 1'b0);
        @(negedge clk); wb(1'b1, 4'd8, 32'h66); #1;
        chk("t6_x0_wb", bus.sb_busy, 1'b1);
        @(negedge clk); wb(1'b0, 4'd0, 32'h0); #1;
        chk("t6_idle", bus.sb_busy, 1'b0);
        drive(1'b1, 32'h508, ADD_X10); #1;
        chk("t6_reader_ready", bus.in_ready, 1'b1);
        @(negedge clk); drive(1'b0, 32'h0, NOP); #1;
        chk("t6_reader_rs1", bus.out_rs1_data, 32'h66);
        chk("t6_reader_rs2_x0", bus.out_rs2_data, 32'h0);
        chk("t6_reader_rd", bus.out_rd, 4'd10);

        // asynchronous reset mid-operation
        @(negedge clk); bus.out_ready = 1'b0; drive(1'b1, 32'h600, ADDI_X5); #1;
        chk("t1_pending", bus.sb_busy, 1'b1);
        @(negedge clk); #1;
        chk("t1_entry", bus.out_valid, 1'b1);
        reset = 1'b0; #1;
        chk("t1_drop_valid", bus.out_valid, 1'b0);
        chk("t1_drop_busy", bus.sb_busy, 1'b0);
        chk("t1_drop_ready", bus.in_ready, 1'b0);
        chk("t1_drop_pc", bus.out_pc, 32'h0);
        @(negedge clk); #1;
        chk("t1_held_ready", bus.in_ready, 1'b0);
        reset = 1'b1; #1;
        chk("t1_release_ready", bus.in_ready, 1'b1);
        chk("t1_release_valid", bus.out_valid, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
